sys_bridge_mc: RTL and testbench

Parametrised multi-channel system bridge between the single CPU master port and N_CH target sockets, such as BIOS, control, VGA and RAM. It decodes each CPU address against per-channel base/mask windows and forwards the request as a window-relative offset on the winning channel. It runs the request/acknowledge handshake on both sides, returns read data, and flags decode misses and target timeouts as bus errors.

---
 rtl/sys_bridge_mc.sv | 201 ++++++++++++++++++++
 tb/tb_sys_bridge_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_mc.sv
// Multi-channel CPU-to-target bridge: window decode, four-phase handshake, error reporting.
// Optional target timeout is enabled by defining BRIDGE_TIMEOUT_EN.
module sys_bridge_mc #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned N_CH = 4,
   parameter logic [N_CH*AW-1:0] WIN_BASE =
      {32'h0020_0000, 32'h0010_0000, 32'h0000_8000, 32'h0000_0000},
   parameter logic [N_CH*AW-1:0] WIN_MASK =
      {32'hFFE0_0000, 32'hFFF0_0000, 32'hFFFF_C000, 32'hFFFF_8000},
   parameter int unsigned TO_CYCLES = 255,
   parameter int unsigned TW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [AW-1:0]      cpu_addr,
   input  logic [DW-1:0]      cpu_wdata,
   output logic               cpu_ack,
   output logic               cpu_err,
   output logic [DW-1:0]      cpu_rdata,
   output logic [N_CH-1:0]    tgt_req,
   output logic               tgt_we,
   output logic [AW-1:0]      tgt_addr,
   output logic [DW-1:0]      tgt_wdata,
   input  logic [N_CH*DW-1:0] tgt_rdata,
   input  logic [N_CH-1:0]    tgt_ack,
   output logic               busy,
   output logic [15:0]        err_count
);

   localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [N_CH-1:0] req_q, req_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [15:0]     err_cnt_q, err_cnt_d;
   logic            err_inc;

   // Decode: scanning downwards leaves the lowest-index hit as the winner.
   logic            hit;
   logic [CW-1:0]   win;
   logic [AW-1:0]   win_mask;

   always_comb begin
      hit      = 1'b0;
      win      = '0;
      win_mask = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if ((cpu_addr & WIN_MASK[k*AW +: AW]) == WIN_BASE[k*AW +: AW]) begin
            hit      = 1'b1;
            win      = CW'(k);
            win_mask = WIN_MASK[k*AW +: AW];
         end
      end
   end

`ifdef BRIDGE_TIMEOUT_EN
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_expired;

   assign to_expired = (to_cnt_q == TW'(TO_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic unused_to_cfg;
   assign unused_to_cfg = ^{TW, TO_CYCLES};
`endif

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      req_d   = req_q;
      ack_d   = ack_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      err_inc = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               if (hit) begin
                  ch_d    = win;
                  we_d    = cpu_we;
                  addr_d  = cpu_addr & ~win_mask;
                  wdata_d = cpu_wdata;
                  req_d   = N_CH'(1) << win;
`ifdef BRIDGE_TIMEOUT_EN
                  to_cnt_d = '0;
`endif
                  state_d = StWait;
               end else begin
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = '0;
                  err_inc = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StWait: begin
            // Only the selected channel's ack counts; it beats a same-edge timeout.
            if (tgt_ack[ch_q]) begin
               req_d = '0;
               if (!we_q) begin
                  rdata_d = tgt_rdata[ch_q*DW +: DW];
               end
               ack_d   = 1'b1;
               err_d   = 1'b0;
               state_d = StResp;
            end
`ifdef BRIDGE_TIMEOUT_EN
            else if (to_expired) begin
               req_d = '0;
               if (!we_q) begin
                  rdata_d = '1;
               end
               ack_d   = 1'b1;
               err_d   = 1'b1;
               err_inc = 1'b1;
               state_d = StResp;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         StResp: begin
            if (!cpu_req) begin
               ack_d   = 1'b0;
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_inc && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         ch_q      <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         req_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         req_q     <= req_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign cpu_ack   = ack_q;
   assign cpu_err   = err_q;
   assign cpu_rdata = rdata_q;
   assign tgt_req   = req_q;
   assign tgt_we    = we_q;
   assign tgt_addr  = addr_q;
   assign tgt_wdata = wdata_q;
   assign busy      = (state_q != StIdle);
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_sys_bridge_mc.sv
// Directed bench for sys_bridge_mc; covers the timeout path when BRIDGE_TIMEOUT_EN is defined.
module tb_sys_bridge_mc;

   logic           clk;
   logic           rst;
   logic           cpu_req;
   logic           cpu_we;
   logic [31:0]    cpu_addr;
   logic [31:0]    cpu_wdata;
   logic           cpu_ack;
   logic           cpu_err;
   logic [31:0]    cpu_rdata;
   logic [3:0]     tgt_req;
   logic           tgt_we;
   logic [31:0]    tgt_addr;
   logic [31:0]    tgt_wdata;
   logic [127:0]   tgt_rdata;
   logic [3:0]     tgt_ack;
   logic           busy;
   logic [15:0]    err_count;

   int errors = 0;
   int checks = 0;

   sys_bridge_mc #(
      .TO_CYCLES(4),
      .TW(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack),
      .cpu_err(cpu_err),
      .cpu_rdata(cpu_rdata),
      .tgt_req(tgt_req),
      .tgt_we(tgt_we),
      .tgt_addr(tgt_addr),
      .tgt_wdata(tgt_wdata),
      .tgt_rdata(tgt_rdata),
      .tgt_ack(tgt_ack),
      .busy(busy),
      .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      tgt_rdata = '0;
      tgt_ack   = '0;
      #1;
      check("rst_ack", 64'(cpu_ack), 64'h0);
      check("rst_req", 64'(tgt_req), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_rdata", 64'(cpu_rdata), 64'h0);
      check("rst_errcnt", 64'(err_count), 64'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Read 0x10 on channel 0, acked three cycles after tgt_req.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_0010;
      tick();
      check("rd0_req", 64'(tgt_req), 64'h1);
      check("rd0_addr", 64'(tgt_addr), 64'h10);
      check("rd0_we", 64'(tgt_we), 64'h0);
      check("rd0_busy", 64'(busy), 64'h1);
      check("rd0_noack", 64'(cpu_ack), 64'h0);
      tick();
      tick();
      tgt_ack            = 4'b0001;
      tgt_rdata[31:0]    = 32'hCAFE_0001;
      tick();
      tgt_ack            = 4'b0000;
      check("rd0_ack", 64'(cpu_ack), 64'h1);
      check("rd0_err", 64'(cpu_err), 64'h0);
      check("rd0_rdata", 64'(cpu_rdata), 64'hCAFE_0001);
      check("rd0_reqoff", 64'(tgt_req), 64'h0);
      cpu_addr = 32'h8000_0000;
      tick();
      check("rd0_hold", 64'(cpu_ack), 64'h1);
      cpu_req = 1'b0;
      tick();
      check("rd0_release", 64'(cpu_ack), 64'h0);
      check("rd0_idle", 64'(busy), 64'h0);
      check("rd0_keep", 64'(cpu_rdata), 64'hCAFE_0001);

      // Write 0x0010_0004 routes to channel 2 with offset 0x4.
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h0010_0004;
      cpu_wdata = 32'h0000_012B;
      tick();
      check("wr_req", 64'(tgt_req), 64'h4);
      check("wr_we", 64'(tgt_we), 64'h1);
      check("wr_addr", 64'(tgt_addr), 64'h4);
      check("wr_wdata", 64'(tgt_wdata), 64'h12B);
      tgt_ack            = 4'b0100;
      tgt_rdata[95:64]   = 32'hBAD0_BAD0;
      tick();
      tgt_ack            = 4'b0000;
      check("wr_ack", 64'(cpu_ack), 64'h1);
      check("wr_err", 64'(cpu_err), 64'h0);
      check("wr_rdata", 64'(cpu_rdata), 64'hCAFE_0001);
      cpu_req = 1'b0;
      tick();

      // Read 0xB000 on channel 1 with a spurious channel-3 ack first.
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_B000;
      tick();
      check("rd1_req", 64'(tgt_req), 64'h2);
      check("rd1_addr", 64'(tgt_addr), 64'h3000);
      cpu_addr           = 32'h8000_0000;
      tgt_ack            = 4'b1000;
      tgt_rdata[127:96]  = 32'hDEAD_DEAD;
      tick();
      check("rd1_spur", 64'(cpu_ack), 64'h0);
      check("rd1_stable", 64'(tgt_addr), 64'h3000);
      check("rd1_reqheld", 64'(tgt_req), 64'h2);
      tgt_ack            = 4'b1010;
      tgt_rdata[63:32]   = 32'h1111_2222;
      tick();
      tgt_ack            = 4'b0000;
      check("rd1_ack", 64'(cpu_ack), 64'h1);
      check("rd1_rdata", 64'(cpu_rdata), 64'h1111_2222);
      cpu_req = 1'b0;
      tick();

      // Decode miss at 0x8000_0000.
      cpu_req  = 1'b1;
      cpu_addr = 32'h8000_0000;
      tick();
      check("miss_ack", 64'(cpu_ack), 64'h1);
      check("miss_err", 64'(cpu_err), 64'h1);
      check("miss_rdata", 64'(cpu_rdata), 64'h0);
      check("miss_req", 64'(tgt_req), 64'h0);
      check("miss_cnt", 64'(err_count), 64'h1);
      cpu_req = 1'b0;
      tick();
      check("miss_clr", 64'(cpu_err), 64'h0);

      // Read RAM 0x0020_0040 (channel 3) with no target ack.
      cpu_req  = 1'b1;
      cpu_addr = 32'h0020_0040;
      tick();
      check("ram_req", 64'(tgt_req), 64'h8);
      check("ram_addr", 64'(tgt_addr), 64'h40);
      tick();
      tick();
      tick();
      check("ram_wait", 64'(cpu_ack), 64'h0);
`ifdef BRIDGE_TIMEOUT_EN
      tick();
      check("to_ack", 64'(cpu_ack), 64'h1);
      check("to_err", 64'(cpu_err), 64'h1);
      check("to_rdata", 64'(cpu_rdata), 64'hFFFF_FFFF);
      check("to_req", 64'(tgt_req), 64'h0);
      check("to_cnt", 64'(err_count), 64'h2);
      tgt_ack            = 4'b1000;
      tgt_rdata[127:96]  = 32'h5555_5555;
      tick();
      tgt_ack            = 4'b0000;
      check("to_late", 64'(cpu_rdata), 64'hFFFF_FFFF);
      check("to_lateerr", 64'(cpu_err), 64'h1);
`else
      for (int i = 0; i < 8; i++) tick();
      check("ram_stillwait", 64'(cpu_ack), 64'h0);
      check("ram_reqheld", 64'(tgt_req), 64'h8);
      tgt_ack            = 4'b1000;
      tgt_rdata[127:96]  = 32'h5555_5555;
      tick();
      tgt_ack            = 4'b0000;
      check("ram_ack", 64'(cpu_ack), 64'h1);
      check("ram_rdata", 64'(cpu_rdata), 64'h5555_5555);
`endif
      cpu_req = 1'b0;
      tick();
      check("ram_idle", 64'(busy), 64'h0);

      // Asynchronous reset while waiting on channel 0.
      cpu_req  = 1'b1;
      cpu_addr = 32'h0000_0010;
      tick();
      check("rw_req", 64'(tgt_req), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      check("rw_req0", 64'(tgt_req), 64'h0);
      check("rw_busy", 64'(busy), 64'h0);
      check("rw_rdata", 64'(cpu_rdata), 64'h0);
      check("rw_cnt", 64'(err_count), 64'h0);
      check("rw_addr", 64'(tgt_addr), 64'h0);
      tick();
      rst = 1'b0;
      tick();
      check("rw_redo", 64'(tgt_req), 64'h1);
      check("rw_redoaddr", 64'(tgt_addr), 64'h10);
      tgt_ack          = 4'b0001;
      tgt_rdata[31:0]  = 32'h0BAD_F00D;
      tick();
      tgt_ack          = 4'b0000;
      check("rw_ack", 64'(cpu_ack), 64'h1);
      check("rw_data", 64'(cpu_rdata), 64'h0BAD_F00D);
      cpu_req = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
